alu_md: RTL and testbench
=========================

// Module: alu_md
// PURPOSE
//  Execute-stage ALU with an attached multi-cycle multiply/divide unit and HI/LO registers.
//  Parametrised in datapath width. Adds a fuller combinational op set plus a sequential MD engine.
//  Busy is used by hazard logic to stall mfhi/mflo/mult/div.
//  Sits in the EX stage between the ID/EX and EX/MEM pipeline registers.
// PARAMETERS
//  WIDTH     32  datapath width; must be >= 8 and a power of two
//  MULT_LAT   5  cycles that Busy stays high for MULT/MULTU (>= 1)
//  DIV_LAT   10  cycles that Busy stays high for DIV/DIVU (>= 1)
// PORTS
//  clk       in   1         clock; all state updates on the rising edge
//  reset     in   1         synchronous reset, active-high
//  A         in   WIDTH     operand A (rs)
//  B         in   WIDTH     operand B (rt or immediate)
//  ALUCtrl   in   4         combinational op select
//  MDOp      in   3         MD op: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO
//  Start     in   1         issue MDOp this cycle
//  Result    out  WIDTH     combinational ALU result
//  Zero      out  1         (A == B)
//  Busy      out  1         MD engine running
//  HI        out  WIDTH     HI register
//  LO        out  WIDTH     LO register
// BEHAVIOUR
//  Result (combinational, independent of Busy), by ALUCtrl:
//   0 AND, 1 OR, 2 ADD, 3 SUB, 4 XOR, 5 NOR, 6 SLT (signed), 7 SLTU,
//   8 SLL B<<A[S-1:0], 9 SRL, 10 SRA, 11 LUI {B[WIDTH/2-1:0], 0s}, 12-15 -> 0.
//   S = $clog2(WIDTH). ADD/SUB wrap modulo 2^WIDTH.
//  FSM states: IDLE, RUN. Down-counter cnt; latched operands opA and opB.
//  Issue rules:
//   - IDLE & Start & MDOp in 1..4: latch A/B/op; cnt <= LAT-1; go to RUN.
//     Busy = 1 from the next cycle for exactly LAT cycles.
//   - RUN & cnt == 0: write HI/LO; go to IDLE; Busy = 0 on the following cycle.
//   - RUN & cnt != 0: cnt <= cnt-1.
//   - New HI/LO values are visible LAT cycles after the issue edge.
//   - IDLE & Start & MTHI/MTLO: HI or LO <= A on that edge; Busy stays 0.
//   - Start while Busy (any MDOp): ignored; it does not queue.
//   - MDOp 0 or 7 with Start: no effect.
//  Arithmetic:
//   - MULT/MULTU: {HI,LO} = 2*WIDTH-bit signed/unsigned product.
//   - DIV/DIVU: LO = quotient truncated toward zero; HI = remainder, sign of dividend.
//   - Divide by zero: LO = all ones, HI = dividend.
//   - Signed MIN / -1: LO = MIN, HI = 0.
//  Operands are sampled only at issue; A/B changes during RUN have no effect.
//  Reset (any state, including mid-RUN): state IDLE, cnt 0, Busy 0, HI 0, LO 0.
//  The in-flight result is discarded.
// CONFIGURATION
//  ALU_OVERFLOW_EN defined:
//   - adds output Overflow (1 bit, combinational).
//   - Overflow = 1 on signed overflow of ADD (ALUCtrl 2) or SUB (ALUCtrl 3); 0 for all other ops.
//  Not defined: the Overflow port and its logic are absent; all other behaviour is identical.
// STRUCTURE
//  Package alu_md_pkg holds:
//   - ALUCtrl codes (ALU_AND..ALU_LUI) and MDOp codes (MD_NONE..MD_MTLO) as localparams;
//   - FSM state encoding (ST_IDLE, ST_RUN).
//  Sub-module md_core (clk, reset, Start, MDOp, A, B -> Busy, HI, LO) holds the FSM,
//  counter and HI/LO registers. The top holds the combinational ALU and instantiates md_core.
//  The product/quotient may be computed behaviourally at issue or at completion;
//  the only requirement is cycle-exact Busy and HI/LO timing.
// TESTING
//  1. ALU: A=0x8000_0000, B=1 -> SLT Result=1, SLTU Result=0; SRA by A=4, B=0xF000_0000 -> 0xFF00_0000.
//  2. MULT A=-3 (0xFFFF_FFFD), B=7, Start -> Busy high 5 cycles; then HI=0xFFFF_FFFF, LO=0xFFFF_FFEB.
//  3. DIV A=-7, B=2 -> after 10 Busy cycles LO=0xFFFF_FFFD (-3), HI=0xFFFF_FFFF (-1).
//     DIVU A=7, B=0 -> LO=0xFFFF_FFFF, HI=7.
//  4. Start MULT, then Start DIV and MTHI while Busy -> both ignored;
//     Busy falls after exactly MULT_LAT cycles and HI/LO hold the MULT result.
//  5. Issue DIV, assert reset at busy cycle 4 -> next cycle Busy=0, HI=LO=0;
//     no late write occurs in the following 10 cycles.
//  6. ALU_OVERFLOW_EN: ADD 0x7FFF_FFFF + 1 -> Overflow=1;
//     SUB 0x8000_0000 - 1 -> 1; ADD 1 + 1 -> 0.

Source files
------------

// File: rtl/alu_md_pkg.sv
// Shared op codes and FSM encoding for the EX-stage ALU and its multiply/divide engine.
package alu_md_pkg;

  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_SUB  = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_t;

endpackage

// File: rtl/alu_md_core.sv
// Multi-cycle multiply/divide engine with HI/LO registers; operands are latched at issue
// and the result is computed from the latched copies when the countdown expires.
module md_core
  import alu_md_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [2:0]       MDOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int unsigned MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int unsigned CW      = $clog2(MAX_LAT + 1);

  md_state_t        state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [2:0]       op;
  logic [2*WIDTH-1:0] md_res;

  // Signed divide works on magnitudes so MIN / -1 wraps back to MIN with no special case.
  function automatic logic [2*WIDTH-1:0] md_calc(input logic [2:0] f,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    logic [2*WIDTH-1:0] xa, xb;
    logic [WIDTH-1:0]   ma, mb, q, r;
    md_calc = '0;
    xa = '0;
    xb = '0;
    ma = '0;
    mb = '0;
    q  = '0;
    r  = '0;
    case (f)
      MD_MULT: begin
        xa = {{WIDTH{a[WIDTH-1]}}, a};
        xb = {{WIDTH{b[WIDTH-1]}}, b};
        md_calc = xa * xb;
      end
      MD_MULTU: begin
        xa = {{WIDTH{1'b0}}, a};
        xb = {{WIDTH{1'b0}}, b};
        md_calc = xa * xb;
      end
      MD_DIV: begin
        if (b == '0) begin
          md_calc = {a, {WIDTH{1'b1}}};
        end else begin
          ma = a[WIDTH-1] ? WIDTH'(-a) : a;
          mb = b[WIDTH-1] ? WIDTH'(-b) : b;
          q  = ma / mb;
          r  = ma % mb;
          md_calc = {(a[WIDTH-1] ? WIDTH'(-r) : r),
                     ((a[WIDTH-1] ^ b[WIDTH-1]) ? WIDTH'(-q) : q)};
        end
      end
      MD_DIVU: begin
        if (b == '0) md_calc = {a, {WIDTH{1'b1}}};
        else         md_calc = {a % b, a / b};
      end
      default: md_calc = '0;
    endcase
  endfunction

  always_comb begin
    md_res = md_calc(op, opa, opb);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      Busy  <= 1'b0;
      HI    <= '0;
      LO    <= '0;
      opa   <= '0;
      opb   <= '0;
      op    <= MD_NONE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (Start) begin
            case (MDOp)
              MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                opa   <= A;
                opb   <= B;
                op    <= MDOp;
                cnt   <= (MDOp == MD_MULT || MDOp == MD_MULTU) ? CW'(MULT_LAT - 1)
                                                               : CW'(DIV_LAT - 1);
                state <= ST_RUN;
                Busy  <= 1'b1;
              end
              MD_MTHI: HI <= A;
              MD_MTLO: LO <= A;
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          if (cnt == '0) begin
            HI    <= md_res[2*WIDTH-1:WIDTH];
            LO    <= md_res[WIDTH-1:0];
            state <= ST_IDLE;
            Busy  <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_md.sv
// EX-stage combinational ALU plus the md_core multiply/divide engine.
// Optional Overflow output is enabled by defining ALU_OVERFLOW_EN.
module alu_md
  import alu_md_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUCtrl,
  input  logic [2:0]       MDOp,
  input  logic             Start,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
`ifdef ALU_OVERFLOW_EN
  output logic             Overflow,
`endif
  output logic             Busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int unsigned S = $clog2(WIDTH);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [S-1:0]     sh;

  assign sum  = A + B;
  assign diff = A - B;
  assign sh   = A[S-1:0];
  assign Zero = (A == B);

  always_comb begin
    Result = '0;
    case (ALUCtrl)
      ALU_AND:  Result = A & B;
      ALU_OR:   Result = A | B;
      ALU_ADD:  Result = sum;
      ALU_SUB:  Result = diff;
      ALU_XOR:  Result = A ^ B;
      ALU_NOR:  Result = ~(A | B);
      ALU_SLT:  Result = WIDTH'($signed(A) < $signed(B));
      ALU_SLTU: Result = WIDTH'(A < B);
      ALU_SLL:  Result = B << sh;
      ALU_SRL:  Result = B >> sh;
      ALU_SRA:  Result = WIDTH'($signed(B) >>> sh);
      ALU_LUI:  Result = {B[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      default:  Result = '0;
    endcase
  end

`ifdef ALU_OVERFLOW_EN
  // Signed overflow: operand signs agree (ADD) or differ (SUB) and the result sign flips.
  always_comb begin
    Overflow = 1'b0;
    case (ALUCtrl)
      ALU_ADD: Overflow = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      ALU_SUB: Overflow = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      default: Overflow = 1'b0;
    endcase
  end
`endif

  md_core #(
    .WIDTH   (WIDTH),
    .MULT_LAT(MULT_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_md_core (
    .clk  (clk),
    .reset(reset),
    .Start(Start),
    .MDOp (MDOp),
    .A    (A),
    .B    (B),
    .Busy (Busy),
    .HI   (HI),
    .LO   (LO)
  );

endmodule

// File: tb/tb_alu_md.sv
// Scoreboard bench for alu_md: stimulus queues expected values, a negedge monitor compares them.
module tb_alu_md;
  import alu_md_pkg::*;

  localparam int unsigned W = 32;

  localparam int K_RES  = 0;
  localparam int K_ZERO = 1;
  localparam int K_BUSY = 2;
  localparam int K_HI   = 3;
  localparam int K_LO   = 4;
  localparam int K_OVF  = 5;

  typedef struct {
    int         kind;
    logic [W-1:0] exp;
    string      name;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] A, B;
  logic [3:0]   ALUCtrl;
  logic [2:0]   MDOp;
  logic         Start;
  logic [W-1:0] Result, HI, LO;
  logic         Zero, Busy;
`ifdef ALU_OVERFLOW_EN
  logic         Overflow;
`endif

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  alu_md #(.WIDTH(W), .MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk     (clk),
    .reset   (reset),
    .A       (A),
    .B       (B),
    .ALUCtrl (ALUCtrl),
    .MDOp    (MDOp),
    .Start   (Start),
    .Result  (Result),
    .Zero    (Zero),
`ifdef ALU_OVERFLOW_EN
    .Overflow(Overflow),
`endif
    .Busy    (Busy),
    .HI      (HI),
    .LO      (LO)
  );

  always #5 clk = ~clk;

  // Monitor: every queued expectation is checked at the next falling edge.
  exp_t         mon_e;
  logic [W-1:0] mon_act;
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      mon_e = sb.pop_front();
      case (mon_e.kind)
        K_RES:   mon_act = Result;
        K_ZERO:  mon_act = W'(Zero);
        K_BUSY:  mon_act = W'(Busy);
        K_HI:    mon_act = HI;
        K_LO:    mon_act = LO;
`ifdef ALU_OVERFLOW_EN
        K_OVF:   mon_act = W'(Overflow);
`endif
        default: mon_act = 'x;
      endcase
      vectors++;
      if (mon_act !== mon_e.exp) begin
        miscompares++;
        $display("FAIL %s: got %h expected %h", mon_e.name, mon_act, mon_e.exp);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input int kind, input logic [W-1:0] v, input string name);
    exp_t e;
    e.kind = kind;
    e.exp  = v;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic alu(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] r, input string name);
    ALUCtrl = c;
    A = a;
    B = b;
    expect_v(K_RES, r, name);
    step();
  endtask

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    MDOp = op;
    A = a;
    B = b;
    Start = 1'b1;
    expect_v(K_BUSY, '0, "busy_before_issue");
    step();
    Start = 1'b0;
    MDOp = MD_NONE;
  endtask

  task automatic run_check(input int lat, input logic [W-1:0] hi, input logic [W-1:0] lo,
                           input string name);
    for (int i = 0; i < lat; i++) begin
      expect_v(K_BUSY, W'(1), {name, "_busy"});
      step();
    end
    expect_v(K_BUSY, '0, {name, "_busy_fall"});
    expect_v(K_HI, hi, {name, "_hi"});
    expect_v(K_LO, lo, {name, "_lo"});
    step();
  endtask

  initial begin
    reset = 1'b1;
    A = '0;
    B = '0;
    ALUCtrl = ALU_AND;
    MDOp = MD_NONE;
    Start = 1'b0;
    step();
    step();
    expect_v(K_BUSY, '0, "reset_busy");
    expect_v(K_HI, '0, "reset_hi");
    expect_v(K_LO, '0, "reset_lo");
    step();
    reset = 1'b0;

    // Combinational ALU
    alu(ALU_SLT,  32'h8000_0000, 32'h1, 32'h1, "slt");
    alu(ALU_SLTU, 32'h8000_0000, 32'h1, 32'h0, "sltu");
    alu(ALU_SRA,  32'h4, 32'hF000_0000, 32'hFF00_0000, "sra");
    alu(ALU_SRL,  32'h4, 32'hF000_0000, 32'h0F00_0000, "srl");
    alu(ALU_SLL,  32'h4, 32'h0000_00F1, 32'h0000_0F10, "sll");
    alu(ALU_AND,  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, "and");
    alu(ALU_OR,   32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFFF0_0FFF, "or");
    alu(ALU_XOR,  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFF00_0FF0, "xor");
    alu(ALU_NOR,  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h000F_F000, "nor");
    alu(ALU_ADD,  32'h7FFF_FFFF, 32'h1, 32'h8000_0000, "add_wrap");
    alu(ALU_SUB,  32'h5, 32'h7, 32'hFFFF_FFFE, "sub_neg");
    alu(ALU_LUI,  32'h0, 32'h1234_ABCD, 32'hABCD_0000, "lui");
    alu(4'd12,    32'hFFFF_FFFF, 32'h1, 32'h0, "op12");
    ALUCtrl = ALU_SUB;
    A = 32'h5;
    B = 32'h5;
    expect_v(K_ZERO, W'(1), "zero_eq");
    expect_v(K_RES, '0, "sub_eq");
    step();
    B = 32'h6;
    expect_v(K_ZERO, '0, "zero_ne");
    step();

`ifdef ALU_OVERFLOW_EN
    ALUCtrl = ALU_ADD; A = 32'h7FFF_FFFF; B = 32'h1;
    expect_v(K_OVF, W'(1), "ovf_add");
    step();
    ALUCtrl = ALU_SUB; A = 32'h8000_0000; B = 32'h1;
    expect_v(K_OVF, W'(1), "ovf_sub");
    step();
    ALUCtrl = ALU_ADD; A = 32'h1; B = 32'h1;
    expect_v(K_OVF, '0, "ovf_none");
    step();
    ALUCtrl = ALU_AND; A = 32'h7FFF_FFFF; B = 32'h7FFF_FFFF;
    expect_v(K_OVF, '0, "ovf_and");
    step();
`endif

    // Multiply / divide
    issue(MD_MULT, 32'hFFFF_FFFD, 32'h7);
    run_check(5, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult");
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'h2);
    run_check(5, 32'h1, 32'hFFFF_FFFE, "multu");
    issue(MD_DIV, 32'hFFFF_FFF9, 32'h2);
    run_check(10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div");
    issue(MD_DIV, 32'h7, 32'hFFFF_FFFE);
    run_check(10, 32'h1, 32'hFFFF_FFFD, "div_negdiv");
    issue(MD_DIVU, 32'h7, 32'h0);
    run_check(10, 32'h7, 32'hFFFF_FFFF, "divu_by0");
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_check(10, 32'h0, 32'h8000_0000, "div_min");

    // MTHI/MTLO in idle, and no-op codes
    MDOp = MD_MTHI; A = 32'h1111_2222; Start = 1'b1;
    step();
    MDOp = MD_MTLO; A = 32'h3333_4444;
    expect_v(K_HI, 32'h1111_2222, "mthi");
    expect_v(K_BUSY, '0, "mthi_busy");
    step();
    MDOp = 3'd7; A = 32'h5555_6666;
    expect_v(K_LO, 32'h3333_4444, "mtlo");
    step();
    Start = 1'b0; MDOp = MD_NONE;
    expect_v(K_HI, 32'h1111_2222, "op7_hi");
    expect_v(K_LO, 32'h3333_4444, "op7_lo");
    expect_v(K_BUSY, '0, "op7_busy");
    step();

    // Starts while busy are dropped; operand changes mid-run do not matter
    issue(MD_MULT, 32'h6, 32'h7);
    for (int i = 0; i < 5; i++) begin
      Start = 1'b0;
      MDOp = MD_NONE;
      if (i == 1) begin Start = 1'b1; MDOp = MD_DIV;  A = 32'd100;       B = 32'd3; end
      if (i == 2) begin Start = 1'b1; MDOp = MD_MTHI; A = 32'hDEAD_BEEF; B = 32'd9; end
      expect_v(K_BUSY, W'(1), "ignore_busy");
      step();
    end
    Start = 1'b0;
    MDOp = MD_NONE;
    expect_v(K_BUSY, '0, "ignore_busy_fall");
    expect_v(K_HI, 32'h0, "ignore_hi");
    expect_v(K_LO, 32'h2A, "ignore_lo");
    step();
    expect_v(K_BUSY, '0, "ignore_no_queue");
    step();

    // Reset mid-run discards the in-flight divide
    issue(MD_DIV, 32'd100, 32'd7);
    for (int i = 0; i < 4; i++) begin
      expect_v(K_BUSY, W'(1), "rst_busy");
      if (i == 3) reset = 1'b1;
      step();
    end
    reset = 1'b0;
    for (int i = 0; i < 11; i++) begin
      expect_v(K_BUSY, '0, "rst_busy_low");
      expect_v(K_HI, '0, "rst_hi");
      expect_v(K_LO, '0, "rst_lo");
      step();
    end

    step();
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
